// File: rtl/vending_ctrl_mc.sv
// ---------------------------------------------------------------------------
// vending_ctrl_mc
// Parametrised multi-currency vending controller. It sits between the user
// facing coin / selection / client-ID signals and the dispense / change
// outputs. It tracks credit, per-item stock and session idle time, refuses
// vends whose change would exceed MAX_CHANGE, and can optionally award
// loyalty points.
//
// Optional feature macro: LOYALTY_POINTS_EN
//   defined   -> client_points = min(price >> POINT_SHIFT, 255) after a vend,
//                cleared at session start
//   undefined -> client_points tied to 0
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   id_valid       in   client identified, starts a session from IDLE
//   client_id      in   [8:0] client number, latched with id_valid
//   coin_in        in   [5:0] coin face value
//   currency_type  in   [1:0] multiplier 0:x1 1:x10 2:x100 3:invalid
//   coin_insert    in   single-cycle coin strobe
//   item_select    in   [NUM_ITEMS-1:0] one-hot item choice
//   confirm        in   purchase request, or cancel when nothing selected
//   restock        in   reload all stock counters (IDLE only)
//   item_out       out  [NUM_ITEMS-1:0] one-hot dispense pulse
//   change_out     out  [CREDIT_W-1:0] change amount, valid with change_valid
//   change_valid   out  single-cycle change strobe
//   no_change      out  pulse: vend refused, change would exceed MAX_CHANGE
//   coin_reject    out  pulse: coin refused
//   credit         out  [CREDIT_W-1:0] current session credit
//   busy           out  controller not idle
//   client_points  out  [7:0] points from the last vend
//   item_empty     out  [NUM_ITEMS-1:0] bit i set when item i is sold out
// ---------------------------------------------------------------------------
module vending_ctrl_mc #(
    parameter int NUM_ITEMS      = 4,
    parameter int CREDIT_W       = 16,
    parameter int STOCK_W        = 4,
    parameter int STOCK_INIT     = 10,
    parameter int PRICE_BASE     = 50,
    parameter int PRICE_STEP     = 25,
    parameter int MAX_CHANGE     = 500,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int POINT_SHIFT    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [8:0]           client_id,
    input  logic [5:0]           coin_in,
    input  logic [1:0]           currency_type,
    input  logic                 coin_insert,
    input  logic [NUM_ITEMS-1:0] item_select,
    input  logic                 confirm,
    input  logic                 restock,
    output logic [NUM_ITEMS-1:0] item_out,
    output logic [CREDIT_W-1:0]  change_out,
    output logic                 change_valid,
    output logic                 no_change,
    output logic                 coin_reject,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 busy,
    output logic [7:0]           client_points,
    output logic [NUM_ITEMS-1:0] item_empty
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SESSION = 2'd1,
        ST_VEND    = 2'd2,
        ST_CHANGE  = 2'd3
    } state_t;

    // Wide enough for credit plus the largest coin (63 * 100) without wrap.
    localparam int EXT_W = CREDIT_W + 14;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [STOCK_W-1:0]   STOCK_INIT_V  = STOCK_W'(STOCK_INIT);
    localparam logic [NUM_ITEMS-1:0] EMPTY_INIT_V  = {NUM_ITEMS{(STOCK_INIT == 0)}};
    localparam logic [TMR_W-1:0]     TIMER_LAST_V  = TMR_W'(TIMEOUT_CYCLES - 1);

    function automatic logic is_onehot(input logic [NUM_ITEMS-1:0] v);
        return (v != '0) && ((v & (v - NUM_ITEMS'(1))) == '0);
    endfunction

    state_t                 state_r;
    logic [CREDIT_W-1:0]    credit_r;
    logic [NUM_ITEMS-1:0]   sel_r;
    logic [TMR_W-1:0]       timer_r;
    logic [8:0]             client_id_r;
    logic [STOCK_W-1:0]     stock_r [NUM_ITEMS];
    logic [NUM_ITEMS-1:0]   item_out_r;
    logic [CREDIT_W-1:0]    change_out_r;
    logic                   change_valid_r;
    logic                   no_change_r;
    logic                   coin_reject_r;
    logic                   busy_r;
    logic [NUM_ITEMS-1:0]   item_empty_r;

    logic                   sel_onehot_s;
    logic [NUM_ITEMS-1:0]   sel_eff_s;
    logic [CREDIT_W-1:0]    price_s;
    logic [STOCK_W-1:0]     stock_sel_s;
    logic [6:0]             mult_s;
    logic [EXT_W-1:0]       coin_value_s;
    logic [EXT_W-1:0]       coin_sum_s;
    logic                   coin_ok_s;
    logic                   affordable_s;
    logic [CREDIT_W-1:0]    change_left_s;
    logic                   change_too_big_s;
    logic                   activity_s;
    logic                   client_id_unused_s;

    // The latched client number has no consumer inside this block.
    assign client_id_unused_s = ^client_id_r;

    // Selection, price lookup, coin valuation and purchase qualification.
    always_comb begin
        sel_onehot_s = is_onehot(item_select);
        // A one-hot selection in the same SESSION cycle takes effect at once.
        if ((state_r == ST_SESSION) && sel_onehot_s) begin
            sel_eff_s = item_select;
        end else begin
            sel_eff_s = sel_r;
        end

        price_s     = '0;
        stock_sel_s = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            price_s     = sel_eff_s[i] ? CREDIT_W'(PRICE_BASE + i * PRICE_STEP) : price_s;
            stock_sel_s = sel_eff_s[i] ? stock_r[i] : stock_sel_s;
        end

        case (currency_type)
            2'd0:    mult_s = 7'd1;
            2'd1:    mult_s = 7'd10;
            2'd2:    mult_s = 7'd100;
            default: mult_s = 7'd0;
        endcase

        coin_value_s     = EXT_W'(coin_in) * EXT_W'(mult_s);
        coin_sum_s       = EXT_W'(credit_r) + coin_value_s;
        coin_ok_s        = (currency_type != 2'd3) && (coin_sum_s[EXT_W-1:CREDIT_W] == '0);
        affordable_s     = (credit_r >= price_s);
        change_left_s    = credit_r - price_s;
        change_too_big_s = (EXT_W'(change_left_s) > EXT_W'(MAX_CHANGE));
        activity_s       = coin_insert | (item_select != '0) | confirm;
    end

    // Main controller: state, credit, selection, timer, stock and all strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            credit_r       <= '0;
            sel_r          <= '0;
            timer_r        <= '0;
            client_id_r    <= 9'd0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_r[i] <= STOCK_INIT_V;
            end
            item_out_r     <= '0;
            change_out_r   <= '0;
            change_valid_r <= 1'b0;
            no_change_r    <= 1'b0;
            coin_reject_r  <= 1'b0;
            busy_r         <= 1'b0;
            item_empty_r   <= EMPTY_INIT_V;
        end else begin
            item_out_r     <= '0;
            change_valid_r <= 1'b0;
            no_change_r    <= 1'b0;
            coin_reject_r  <= 1'b0;
            busy_r         <= (state_r != ST_IDLE);

            case (state_r)
                ST_IDLE: begin
                    if (id_valid) begin
                        client_id_r <= client_id;
                        credit_r    <= '0;
                        sel_r       <= '0;
                        timer_r     <= '0;
                        state_r     <= ST_SESSION;
                    end
                    if (restock) begin
                        for (int i = 0; i < NUM_ITEMS; i++) begin
                            stock_r[i] <= STOCK_INIT_V;
                        end
                        item_empty_r <= EMPTY_INIT_V;
                    end
                end

                ST_SESSION: begin
                    if (activity_s) begin
                        timer_r <= '0;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                    end

                    if (sel_onehot_s) begin
                        sel_r <= item_select;
                    end

                    if (coin_insert) begin
                        // A confirm arriving with a coin is dropped.
                        if (coin_ok_s) begin
                            credit_r <= coin_sum_s[CREDIT_W-1:0];
                        end else begin
                            coin_reject_r <= 1'b1;
                        end
                    end else if (confirm) begin
                        if (sel_eff_s == '0) begin
                            state_r <= ST_CHANGE;
                        end else if ((stock_sel_s == '0) || !affordable_s) begin
                            state_r <= ST_SESSION;
                        end else if (change_too_big_s) begin
                            // Refused vend drops the selection so that a
                            // following bare confirm cancels the session.
                            no_change_r <= 1'b1;
                            sel_r       <= '0;
                        end else begin
                            state_r <= ST_VEND;
                        end
                    end else if (!activity_s && (timer_r == TIMER_LAST_V)) begin
                        state_r <= ST_CHANGE;
                    end
                end

                ST_VEND: begin
                    item_out_r <= sel_r;
                    for (int i = 0; i < NUM_ITEMS; i++) begin
                        if (sel_r[i]) begin
                            stock_r[i]      <= stock_r[i] - STOCK_W'(1);
                            item_empty_r[i] <= (stock_r[i] == STOCK_W'(1));
                        end
                    end
                    credit_r <= credit_r - price_s;
                    state_r  <= ST_CHANGE;
                end

                ST_CHANGE: begin
                    change_out_r   <= credit_r;
                    change_valid_r <= 1'b1;
                    credit_r       <= '0;
                    sel_r          <= '0;
                    state_r        <= ST_IDLE;
                end

                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LOYALTY_POINTS_EN
    logic [CREDIT_W-1:0] points_raw_s;
    logic [7:0]          points_r;

    assign points_raw_s = price_s >> POINT_SHIFT;

    // Loyalty points: cleared at session start, loaded (saturated) on a vend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            points_r <= 8'd0;
        end else if ((state_r == ST_IDLE) && id_valid) begin
            points_r <= 8'd0;
        end else if (state_r == ST_VEND) begin
            points_r <= (points_raw_s > CREDIT_W'(255)) ? 8'd255 : points_raw_s[7:0];
        end else begin
            points_r <= points_r;
        end
    end

    assign client_points = points_r;
`else
    localparam int POINT_SHIFT_UNUSED = POINT_SHIFT;
    assign client_points = 8'd0;
`endif

    assign item_out     = item_out_r;
    assign change_out   = change_out_r;
    assign change_valid = change_valid_r;
    assign no_change    = no_change_r;
    assign coin_reject  = coin_reject_r;
    assign credit       = credit_r;
    assign busy         = busy_r;
    assign item_empty   = item_empty_r;

endmodule

// File: tb/tb_vending_ctrl_mc.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for vending_ctrl_mc (TIMEOUT_CYCLES = 8).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point, i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_vending_ctrl_mc;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [8:0]  client_id;
    logic [5:0]  coin_in;
    logic [1:0]  currency_type;
    logic        coin_insert;
    logic [3:0]  item_select;
    logic        confirm;
    logic        restock;
    logic [3:0]  item_out;
    logic [15:0] change_out;
    logic        change_valid;
    logic        no_change;
    logic        coin_reject;
    logic [15:0] credit;
    logic        busy;
    logic [7:0]  client_points;
    logic [3:0]  item_empty;

    int checks = 0;
    int errors = 0;
    int waited;

    vending_ctrl_mc #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .client_id     (client_id),
        .coin_in       (coin_in),
        .currency_type (currency_type),
        .coin_insert   (coin_insert),
        .item_select   (item_select),
        .confirm       (confirm),
        .restock       (restock),
        .item_out      (item_out),
        .change_out    (change_out),
        .change_valid  (change_valid),
        .no_change     (no_change),
        .coin_reject   (coin_reject),
        .credit        (credit),
        .busy          (busy),
        .client_points (client_points),
        .item_empty    (item_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_session(input logic [8:0] id);
        id_valid  = 1'b1;
        client_id = id;
        tick();
        id_valid  = 1'b0;
    endtask

    task automatic coin(input logic [5:0] v, input logic [1:0] cur);
        coin_in       = v;
        currency_type = cur;
        coin_insert   = 1'b1;
        tick();
        coin_insert   = 1'b0;
    endtask

    task automatic pick(input logic [3:0] s);
        item_select = s;
        tick();
        item_select = 4'd0;
    endtask

    task automatic press();
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; client_id = 9'd0; coin_in = 6'd0;
        currency_type = 2'd0; coin_insert = 1'b0; item_select = 4'd0;
        confirm = 1'b0; restock = 1'b0;

        // Reset state, before any clock edge
        #2;
        chk("rst_credit", 32'(credit), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_item_out", 32'(item_out), 32'd0);
        chk("rst_change_valid", 32'(change_valid), 32'd0);
        chk("rst_item_empty", 32'(item_empty), 32'd0);
        chk("rst_points", 32'(client_points), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Vend item 0 with exact credit 5 x10 = 50
        start_session(9'd17);
        coin(6'd5, 2'd1);
        chk("t1_credit", 32'(credit), 32'd50);
        chk("t1_busy", 32'(busy), 32'd1);
        pick(4'b0001);
        press();
        chk("t1_item_out_N", 32'(item_out), 32'd0);
        tick();
        chk("t1_item_out_N1", 32'(item_out), 32'b0001);
        chk("t1_cv_N1", 32'(change_valid), 32'd0);
        chk("t1_credit_after_vend", 32'(credit), 32'd0);
        tick();
        chk("t1_item_out_N2", 32'(item_out), 32'd0);
        chk("t1_cv_N2", 32'(change_valid), 32'd1);
        chk("t1_change_N2", 32'(change_out), 32'd0);
        chk("t1_busy_N2", 32'(busy), 32'd1);
`ifdef LOYALTY_POINTS_EN
        chk("t1_points", 32'(client_points), 32'd3);
`else
        chk("t1_points", 32'(client_points), 32'd0);
`endif
        tick();
        chk("t1_cv_N3", 32'(change_valid), 32'd0);
        chk("t1_busy_N3", 32'(busy), 32'd0);

        // Item 2 (price 100) with credit 200 -> change 100
        start_session(9'd2);
        coin(6'd2, 2'd2);
        chk("t2_credit", 32'(credit), 32'd200);
        pick(4'b0100);
        press();
        tick();
        chk("t2_item_out", 32'(item_out), 32'b0100);
        tick();
        chk("t2_cv", 32'(change_valid), 32'd1);
        chk("t2_change", 32'(change_out), 32'd100);
        chk("t2_item_empty", 32'(item_empty), 32'd0);

        // Credit 700 on item 0 -> change 650 > 500 refused, then cancel
        start_session(9'd3);
        coin(6'd7, 2'd2);
        chk("t3_credit", 32'(credit), 32'd700);
        pick(4'b0001);
        press();
        chk("t3_no_change", 32'(no_change), 32'd1);
        chk("t3_item_out", 32'(item_out), 32'd0);
        tick();
        chk("t3_no_change_pulse", 32'(no_change), 32'd0);
        chk("t3_cv_session", 32'(change_valid), 32'd0);
        chk("t3_busy", 32'(busy), 32'd1);
        press();
        chk("t3_cv_cancel_N", 32'(change_valid), 32'd0);
        tick();
        chk("t3_cv_cancel_N1", 32'(change_valid), 32'd1);
        chk("t3_change", 32'(change_out), 32'd700);
        tick();

        // Invalid currency and credit overflow rejects
        start_session(9'd4);
        coin(6'd5, 2'd3);
        chk("t4_reject_cur3", 32'(coin_reject), 32'd1);
        chk("t4_credit_cur3", 32'(credit), 32'd0);
        for (int i = 0; i < 10; i++) begin
            coin(6'd63, 2'd2);
        end
        chk("t4_credit_max", 32'(credit), 32'd63000);
        chk("t4_no_reject", 32'(coin_reject), 32'd0);
        coin(6'd63, 2'd2);
        chk("t4_reject_ovf", 32'(coin_reject), 32'd1);
        chk("t4_credit_ovf", 32'(credit), 32'd63000);
        tick();
        chk("t4_reject_pulse", 32'(coin_reject), 32'd0);
        press();
        tick();
        chk("t4_cv", 32'(change_valid), 32'd1);
        chk("t4_change", 32'(change_out), 32'd63000);
        tick();

        // Sell out item 3 (price 125, credit 130 -> change 5)
        for (int n = 0; n < 10; n++) begin
            start_session(9'd5);
            coin(6'd13, 2'd1);
            pick(4'b1000);
            press();
            tick();
            chk("t5_item_out", 32'(item_out), 32'b1000);
            tick();
            chk("t5_change", 32'(change_out), 32'd5);
        end
        chk("t5_item_empty", 32'(item_empty), 32'b1000);
        start_session(9'd5);
        coin(6'd13, 2'd1);
        pick(4'b1000);
        press();
        chk("t5_sold_out_item", 32'(item_out), 32'd0);
        chk("t5_sold_out_cv", 32'(change_valid), 32'd0);
        chk("t5_sold_out_busy", 32'(busy), 32'd1);
        tick();
        chk("t5_sold_out_item2", 32'(item_out), 32'd0);
        chk("t5_credit_kept", 32'(credit), 32'd130);
        // Left idle, the session times out 9 edges after the ignored confirm
        waited = 1;
        while ((change_valid !== 1'b1) && (waited < 14)) begin
            tick();
            waited++;
        end
        chk("t5_timeout_edges", 32'(waited), 32'd9);
        chk("t5_timeout_change", 32'(change_out), 32'd130);
        tick();
        restock = 1'b1;
        tick();
        restock = 1'b0;
        chk("t5_restock_empty", 32'(item_empty), 32'd0);

        // Timeout: credit 30, no further activity
        start_session(9'd6);
        coin(6'd3, 2'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t6_no_cv_yet", 32'(change_valid), 32'd0);
        end
        tick();
        chk("t6_cv", 32'(change_valid), 32'd1);
        chk("t6_change", 32'(change_out), 32'd30);
        tick();

        // Asynchronous reset mid-session
        start_session(9'd7);
        coin(6'd5, 2'd1);
        coin(6'd5, 2'd3);
        chk("t7_reject_pre", 32'(coin_reject), 32'd1);
        chk("t7_credit_pre", 32'(credit), 32'd50);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_reject_async", 32'(coin_reject), 32'd0);
        chk("t7_credit_async", 32'(credit), 32'd0);
        chk("t7_busy_async", 32'(busy), 32'd0);
        chk("t7_cv_async", 32'(change_valid), 32'd0);
        tick();
        chk("t7_cv_held_rst", 32'(change_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
